led_blink_ctrl: RTL and testbench

- Selectable-rate LED blinker.
- Four free-running clock dividers each produce a 50%-duty square wave: nominally 1 Hz, 5 Hz, 10 Hz and 20 Hz.
- Two select inputs choose one of the four waves. An enable input gates the chosen wave onto a single registered LED output.
- Sits directly behind board switches and drives one LED pin.

---
 rtl/led_blink_pkg.sv | 23 ++
 rtl/led_blink_ctrl_toggle_divider.sv | 40 ++++
 rtl/led_blink_ctrl.sv | 62 ++++++
 tb/tb_led_blink_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/led_blink_pkg.sv
// Shared constants and encodings for the selectable-rate LED blinker.
package led_blink_pkg;

    // Half-periods in cycles of a 25 MHz clock.
    localparam int unsigned C_HALF_1HZ_DEF  = 12500000;
    localparam int unsigned C_HALF_5HZ_DEF  = 2500000;
    localparam int unsigned C_HALF_10HZ_DEF = 1250000;
    localparam int unsigned C_HALF_20HZ_DEF = 625000;

    localparam int NUM_RATES = 4;

    typedef enum logic [1:0] {
        RATE_20HZ = 2'b00,
        RATE_10HZ = 2'b01,
        RATE_5HZ  = 2'b10,
        RATE_1HZ  = 2'b11
    } rate_e;

    function automatic int unsigned cnt_width(input int unsigned hp);
        return (hp <= 1) ? 1 : $clog2(hp);
    endfunction

endpackage

// File: rtl/led_blink_ctrl_toggle_divider.sv
// Free-running divider: toggle bit inverts every C_HALF_PERIOD cycles.
module toggle_divider
    import led_blink_pkg::*;
#(
    parameter int unsigned C_HALF_PERIOD = C_HALF_1HZ_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_toggle
);

    localparam int unsigned W = cnt_width(C_HALF_PERIOD);
    localparam logic [W-1:0] LAST = W'(C_HALF_PERIOD - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         tog_q, tog_d;

    // Counter stops at LAST and restarts, so no binary wrap is ever used.
    always_comb begin
        cnt_d = cnt_q + W'(1);
        tog_d = tog_q;
        if (cnt_q == LAST) begin
            cnt_d = '0;
            tog_d = ~tog_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            tog_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tog_q <= tog_d;
        end
    end

    assign o_toggle = tog_q;

endmodule

// File: rtl/led_blink_ctrl.sv
// Selectable-rate LED blinker: four free-running dividers, a rate mux and a
// registered, enable-gated LED output.
module led_blink_ctrl
    import led_blink_pkg::*;
#(
    parameter int unsigned c_max_count_1Hz  = C_HALF_1HZ_DEF,
    parameter int unsigned c_max_count_5Hz  = C_HALF_5HZ_DEF,
    parameter int unsigned c_max_count_10Hz = C_HALF_10HZ_DEF,
    parameter int unsigned c_max_count_20Hz = C_HALF_20HZ_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    input  logic i_select0,
    input  logic i_select1,
    output logic o_led
);

    // Indexed by rate_e encoding.
    localparam int unsigned HP [NUM_RATES] = '{
        c_max_count_20Hz, c_max_count_10Hz, c_max_count_5Hz, c_max_count_1Hz
    };

    logic [NUM_RATES-1:0] tog;
    rate_e                sel;
    logic                 sel_tog;
    logic                 led_q, led_d;

    for (genvar g = 0; g < NUM_RATES; g++) begin : g_div
        toggle_divider #(
            .C_HALF_PERIOD(HP[g])
        ) u_div (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .o_toggle(tog[g])
        );
    end

    assign sel = rate_e'({i_select1, i_select0});

    always_comb begin
        sel_tog = 1'b0;
        case (sel)
            RATE_20HZ: sel_tog = tog[0];
            RATE_10HZ: sel_tog = tog[1];
            RATE_5HZ:  sel_tog = tog[2];
            RATE_1HZ:  sel_tog = tog[3];
            default:   sel_tog = 1'b0;
        endcase
    end

    // Enable gates the selected wave directly, so a disable always wins.
    assign led_d = i_enable & sel_tog;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) led_q <= 1'b0;
        else          led_q <= led_d;
    end

    assign o_led = led_q;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Scoreboard bench for led_blink_ctrl with small half-periods (25/10/5/2).
module tb_led_blink_ctrl;

    localparam int H1 = 25, H5 = 10, H10 = 5, H20 = 2;
    localparam int HP [4] = '{H20, H10, H5, H1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    logic s0 = 1'b1, s1 = 1'b1;
    logic led;

    always #5 clk = ~clk;

    led_blink_ctrl #(
        .c_max_count_1Hz (H1),
        .c_max_count_5Hz (H5),
        .c_max_count_10Hz(H10),
        .c_max_count_20Hz(H20)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_enable (en),
        .i_select0(s0),
        .i_select1(s1),
        .o_led    (led)
    );

    int errs = 0, checks = 0;
    int edge_n = 0;
    bit exp_q[$];
    int mcnt [4];
    bit mt   [4];

    task automatic chk(input string tag, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s edge=%0d: got %b expected %b", tag, edge_n, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mcnt[i] = 0;
            mt[i]   = 1'b0;
        end
        exp_q.delete();
        edge_n = 0;
    endtask

    // One clock edge: model predicts, pushes, then DUT output is popped and compared.
    task automatic step(input string tag);
        bit e;
        @(posedge clk);
        e = en & mt[{s1, s0}];
        for (int i = 0; i < 4; i++) begin
            if (mcnt[i] == HP[i] - 1) begin
                mcnt[i] = 0;
                mt[i]   = ~mt[i];
            end else begin
                mcnt[i]++;
            end
        end
        exp_q.push_back(e);
        edge_n++;
        #1;
        if (exp_q.size() == 0) chk({tag, "_empty"}, 1'b1, 1'b0);
        else chk(tag, led, exp_q.pop_front());
    endtask

    task automatic do_reset(input logic e, input logic [1:0] s);
        @(negedge clk);
        rst_n = 1'b0;
        en = e;
        {s1, s0} = s;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 chk("rst_hold", led, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        // Held in reset with enable on and slowest rate selected.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 chk("rst_init", led, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // sel=11: rise at 26, fall at 51.
        for (int i = 0; i < 60; i++) begin
            step("sel11");
            if (edge_n == 25) chk("pre_rise26", led, 1'b0);
            if (edge_n == 26) chk("rise26", led, 1'b1);
            if (edge_n == 50) chk("pre_fall51", led, 1'b1);
            if (edge_n == 51) chk("fall51", led, 1'b0);
        end

        // sel=00: first rise at edge 3.
        do_reset(1'b1, 2'b00);
        for (int i = 0; i < 12; i++) begin
            step("sel00");
            if (edge_n == 2) chk("pre_rise3", led, 1'b0);
            if (edge_n == 3) chk("rise3", led, 1'b1);
            if (edge_n == 5) chk("fall5", led, 1'b0);
        end

        do_reset(1'b1, 2'b01);
        for (int i = 0; i < 25; i++) begin
            step("sel01");
            if (edge_n == 6)  chk("rise6_10hz", led, 1'b1);
            if (edge_n == 11) chk("fall11_10hz", led, 1'b0);
        end

        do_reset(1'b1, 2'b10);
        for (int i = 0; i < 45; i++) begin
            step("sel10");
            if (edge_n == 11) chk("rise11_5hz", led, 1'b1);
            if (edge_n == 21) chk("fall21_5hz", led, 1'b0);
        end

        // Disabled while cycling selects; counters must keep running.
        do_reset(1'b0, 2'b00);
        for (int i = 0; i < 40; i++) begin
            if (edge_n < 36) {s1, s0} = (i % 4 == 0) ? 2'b00 : (i % 4 == 1) ? 2'b01 :
                                        (i % 4 == 2) ? 2'b11 : 2'b10;
            else {s1, s0} = 2'b11;
            step("dis");
            chk("dis_off", led, 1'b0);
        end
        en = 1'b1;
        step("reen");
        if (edge_n == 41) chk("reen41", led, 1'b1);
        for (int i = 0; i < 3; i++) step("reen_run");
        chk("en_hi44", led, 1'b1);
        en = 1'b0;
        step("endrop");
        chk("endrop45", led, 1'b0);
        for (int i = 0; i < 6; i++) step("endrop_run");

        // Select switch mid-period without disturbing the 1 Hz phase.
        do_reset(1'b1, 2'b11);
        for (int i = 0; i < 30; i++) step("sw_a");
        {s1, s0} = 2'b00;
        for (int i = 0; i < 7; i++) step("sw_20");
        {s1, s0} = 2'b11;
        for (int i = 0; i < 20; i++) begin
            step("sw_back");
            if (edge_n == 50) chk("sw_phase50", led, 1'b1);
            if (edge_n == 51) chk("sw_phase51", led, 1'b0);
        end

        // Asynchronous reset mid-cycle while LED is on.
        do_reset(1'b1, 2'b11);
        for (int i = 0; i < 30; i++) step("ar_run");
        chk("ar_pre", led, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", led, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 27; i++) begin
            step("ar_restart");
            if (edge_n == 26) chk("ar_rise26", led, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
